// File: rtl/subtractor_cell.sv
// rtl/subtractor_cell.sv - restoring-divider subtractor cell with ripple borrow and registered copies
module subtractor_cell #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    input  logic             sel,
    output logic             b_out,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             b_out_q
);

    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] out_d;
    logic             b_out_d;

    // Full-subtractor cell per bit; the borrow ripples LSB to MSB and never sees sel,
    // so the row's final borrow may drive sel without forming a loop.
    always_comb begin
        diff   = '0;
        borrow = b_in;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i] = a[i] ^ b[i] ^ borrow;
            borrow  = (~a[i] & b[i]) | (~a[i] & borrow) | (b[i] & borrow);
        end
    end

    assign b_out   = borrow;
    assign out     = sel ? a : diff;
    assign out_d   = out;
    assign b_out_d = b_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            b_out_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            b_out_q <= b_out_d;
        end
    end

endmodule

// File: tb/tb_subtractor_cell.sv
// tb/tb_subtractor_cell.sv - directed self-checking bench for subtractor_cell (WIDTH=1 and WIDTH=8)
module tb_subtractor_cell;

    logic       clk;
    logic       rst_n;

    logic       a1, b1, bin1, sel1;
    logic       bo1, out1, outq1, boq1;

    logic [7:0] a8, b8;
    logic       bin8, sel8;
    logic       bo8, boq8;
    logic [7:0] out8, outq8;

    int errors;
    int checks;

    subtractor_cell #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .b_in(bin1), .sel(sel1),
        .b_out(bo1), .out(out1), .out_q(outq1), .b_out_q(boq1)
    );

    subtractor_cell #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .b_in(bin8), .sel(sel8),
        .b_out(bo8), .out(out8), .out_q(outq8), .b_out_q(boq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent integer model of the 8-bit cell.
    task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic s, output logic [7:0] o, output logic bo);
        int unsigned d;
        d  = 32'(a) + 32'd256 - 32'(b) - 32'(bi);
        bo = (32'(a) < 32'(b) + 32'(bi));
        o  = s ? a : d[7:0];
    endtask

    logic [7:0] exp_o8, hold_o8;
    logic       exp_b8, hold_b8;
    logic       exp_d1, exp_b1;

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        a1 = 0; b1 = 0; bin1 = 0; sel1 = 0;
        a8 = 0; b8 = 0; bin8 = 0; sel8 = 0;

        // Reset holds registers at zero across clock edges.
        #22;
        check("rst_out_q1", 64'(outq1), 64'd0);
        check("rst_bout_q1", 64'(boq1), 64'd0);
        check("rst_out_q8", 64'(outq8), 64'd0);
        check("rst_bout_q8", 64'(boq8), 64'd0);

        // WIDTH=1 directed scenarios.
        a1 = 1; b1 = 0; bin1 = 0; sel1 = 0; #1;
        check("w1_100_out", 64'(out1), 64'd1);
        check("w1_100_bout", 64'(bo1), 64'd0);
        a1 = 1; b1 = 1; bin1 = 0; sel1 = 0; #1;
        check("w1_110_out", 64'(out1), 64'd0);
        check("w1_110_bout", 64'(bo1), 64'd0);
        a1 = 1; b1 = 1; bin1 = 1; sel1 = 1; #1;
        check("w1_111_restore_out", 64'(out1), 64'd1);
        check("w1_111_restore_bout", 64'(bo1), 64'd1);

        // WIDTH=1 exhaustive truth table (while in reset: combinational path keeps tracking).
        for (int v = 0; v < 16; v++) begin
            logic [3:0] vv;
            vv = 4'(v);
            {a1, b1, bin1, sel1} = vv;
            #1;
            exp_d1 = vv[3] ^ vv[2] ^ vv[1];
            exp_b1 = (!vv[3] && (vv[2] || vv[1])) || (vv[2] && vv[1]);
            check($sformatf("w1_exh%0d_out", v), 64'(out1), 64'(vv[0] ? vv[3] : exp_d1));
            check($sformatf("w1_exh%0d_bout", v), 64'(bo1), 64'(exp_b1));
        end
        check("rst_hold_out_q1", 64'(outq1), 64'd0);

        // WIDTH=8 directed scenarios and boundaries.
        a8 = 8'h05; b8 = 8'h07; bin8 = 0; sel8 = 0; #1;
        check("w8_5m7_out", 64'(out8), 64'hFE);
        check("w8_5m7_bout", 64'(bo8), 64'd1);
        sel8 = 1; #1;
        check("w8_5m7_restore_out", 64'(out8), 64'h05);
        check("w8_5m7_restore_bout", 64'(bo8), 64'd1);
        a8 = 8'h00; b8 = 8'h00; bin8 = 1; sel8 = 0; #1;
        check("w8_wrap_out", 64'(out8), 64'hFF);
        check("w8_wrap_bout", 64'(bo8), 64'd1);
        a8 = 8'hFF; b8 = 8'hFF; bin8 = 0; sel8 = 0; #1;
        check("w8_ones_out", 64'(out8), 64'h00);
        check("w8_ones_bout", 64'(bo8), 64'd0);
        a8 = 8'h80; b8 = 8'h01; bin8 = 1; #1;
        check("w8_80_out", 64'(out8), 64'h7E);
        check("w8_80_bout", 64'(bo8), 64'd0);
        a8 = 8'h10; b8 = 8'h10; bin8 = 1; #1;
        check("w8_eq_bin_out", 64'(out8), 64'hFF);
        check("w8_eq_bin_bout", 64'(bo8), 64'd1);
        a8 = 8'h10; b8 = 8'h0F; bin8 = 1; #1;
        check("w8_eq_exact_out", 64'(out8), 64'h00);
        check("w8_eq_exact_bout", 64'(bo8), 64'd0);

        // Registered path: release reset, first edge loads live values.
        @(negedge clk);
        a1 = 1; b1 = 0; bin1 = 0; sel1 = 0;
        a8 = 8'h3C; b8 = 8'h0F; bin8 = 1; sel8 = 0;
        rst_n = 1'b1;
        #1;
        check("pre_edge_out_q1", 64'(outq1), 64'd0);
        @(posedge clk); #1;
        check("reg_out_q1", 64'(outq1), 64'd1);
        check("reg_bout_q1", 64'(boq1), 64'd0);
        check("reg_out_q8", 64'(outq8), 64'h2C);
        check("reg_bout_q8", 64'(boq8), 64'd0);

        // Inputs changing between edges must not disturb the registers.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; bin8 = 0; #1;
        check("hold_out_q8", 64'(outq8), 64'h2C);
        check("live_out8", 64'(out8), 64'hFF);
        @(posedge clk); #1;
        check("next_out_q8", 64'(outq8), 64'hFF);
        check("next_bout_q8", 64'(boq8), 64'd1);

        // Directed sweep against the integer model, checking combinational and registered.
        for (int k = 0; k < 6; k++) begin
            logic [7:0] av [6];
            logic [7:0] bv [6];
            av = '{8'hA5, 8'h00, 8'h7F, 8'hC3, 8'h01, 8'hFE};
            bv = '{8'h5A, 8'h01, 8'h80, 8'hC3, 8'h00, 8'hFF};
            @(negedge clk);
            a8 = av[k]; b8 = bv[k]; bin8 = 1'(k & 1); sel8 = 1'(k == 4);
            model8(a8, b8, bin8, sel8, exp_o8, exp_b8);
            #1;
            check($sformatf("sweep%0d_out", k), 64'(out8), 64'(exp_o8));
            check($sformatf("sweep%0d_bout", k), 64'(bo8), 64'(exp_b8));
            @(posedge clk); #1;
            check($sformatf("sweep%0d_out_q", k), 64'(outq8), 64'(exp_o8));
            check($sformatf("sweep%0d_bout_q", k), 64'(boq8), 64'(exp_b8));
        end

        // Asynchronous reset mid-cycle clears only the registers.
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h07; bin8 = 0; sel8 = 0;
        @(posedge clk); #1;
        hold_o8 = outq8;
        hold_b8 = boq8;
        check("pre_async_out_q8", 64'(hold_o8), 64'hFE);
        check("pre_async_bout_q8", 64'(hold_b8), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_q8", 64'(outq8), 64'd0);
        check("async_bout_q8", 64'(boq8), 64'd0);
        check("async_out_q1", 64'(outq1), 64'd0);
        check("async_live_out8", 64'(out8), 64'hFE);
        check("async_live_bout8", 64'(bo8), 64'd1);
        @(posedge clk); #1;
        check("async_hold_out_q8", 64'(outq8), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/subtractor_cell.md
SUBTRACTOR_CELL -- requirements
Module: subtractor_cell

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH SHALL default to 1 and set the operand width in bits; legal range is 1..64.
REQ-003 Port clk SHALL be an input, 1 bit: rising-edge clock for the registered outputs.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port a SHALL be an input, WIDTH bits: minuend, which is the partial remainder.
REQ-006 Port b SHALL be an input, WIDTH bits: subtrahend, which is the divisor slice.
REQ-007 Port b_in SHALL be an input, 1 bit: borrow-in to the LSB.
REQ-008 Port sel SHALL be an input, 1 bit: restore select, where 1 passes a and 0 passes the difference.
REQ-009 Port b_out SHALL be an output, 1 bit: combinational borrow-out from the MSB.
REQ-010 Port out SHALL be an output, WIDTH bits: combinational cell result.
REQ-011 Port out_q SHALL be an output, WIDTH bits: registered copy of out.
REQ-012 Port b_out_q SHALL be an output, 1 bit: registered copy of b_out.

Function
REQ-013 Arithmetic SHALL be unsigned: diff = (a - b - b_in) mod 2^WIDTH.
REQ-014 b_out SHALL be 1 exactly when a < b + b_in, evaluated as an integer comparison with WIDTH+1-bit precision.
REQ-015 For WIDTH=1 the diff bit SHALL equal a XOR b XOR b_in.
REQ-016 For WIDTH=1, b_out SHALL equal (~a & b) | (~a & b_in) | (b & b_in).
REQ-017 For WIDTH>1 the borrow SHALL ripple bitwise from b_in at bit 0 to b_out at bit WIDTH-1, using the REQ-015/REQ-016 cell per bit.
REQ-018 out SHALL equal a when sel=1 (restore).
REQ-019 out SHALL equal diff when sel=0.
REQ-020 b_out SHALL be independent of sel, so that a row's final borrow can drive sel without a combinational loop through the cell.
REQ-021 out and b_out SHALL be purely combinational, with zero-cycle latency and no dependence on clk or rst_n.
REQ-022 On each rising clk edge with rst_n=1, out_q SHALL take the value of out and b_out_q SHALL take the value of b_out, giving a latency of 1 cycle.
REQ-023 There SHALL be no handshake and no enable; the registers load every cycle.
REQ-024 Boundary: a=0, b=0, b_in=1, sel=0 SHALL give out=all-ones and b_out=1, with wrap-around.
REQ-025 Boundary: a=all-ones, b=all-ones, b_in=0 SHALL give diff=0 and b_out=0.
REQ-026 Any X/Z on sel SHALL not be specially handled; a standard mux semantic applies.

Reset
REQ-027 While rst_n=0, out_q SHALL be 0 and b_out_q SHALL be 0, immediately and independent of clk.
REQ-028 On rst_n deassertion, the first rising clk edge SHALL load the live out and b_out values.
REQ-029 Reset asserted mid-operation SHALL clear only the registered outputs; out and b_out SHALL continue to track the inputs.

Verification
REQ-030 Scenario, WIDTH=1: a=1, b=0, b_in=0, sel=0 -> out=1 and b_out=0.
REQ-031 Scenario, WIDTH=1: a=1, b=1, b_in=0, sel=0 -> out=0 and b_out=0.
REQ-032 Scenario, WIDTH=1: a=1, b=1, b_in=1, sel=1 -> out=1 (restored a) and b_out=1.
REQ-033 Scenario, WIDTH=1: exhaustive 16 combinations of (a, b, b_in, sel) -> outputs match REQ-015 to REQ-019.
REQ-034 Scenario, WIDTH=8: a=0x05, b=0x07, b_in=0, sel=0 -> out=0xFE and b_out=1.
REQ-035 Scenario, WIDTH=8: same inputs with sel=1 -> out=0x05 and b_out=1.
REQ-036 Scenario, registered path: hold rst_n=0 -> out_q=0 and b_out_q=0.
REQ-037 Scenario, registered path: release rst_n with a=1, b=0, b_in=0, sel=0 -> after 1 rising edge, out_q=1 and b_out_q=0.
REQ-038 Scenario, registered path: assert rst_n low between edges -> out_q and b_out_q clear asynchronously.
